// File: rtl/onehot_encoder_reg_if.sv
// Handshake and error-reporting bundle for onehot_encoder_reg.
// slave = encoder side, master = producer/consumer side.
interface onehot_encoder_reg_if #(
    parameter int OH_W      = 5,
    parameter int BIN_W     = 3,
    parameter int ERR_CNT_W = 8
);
    logic [OH_W-1:0]      onehot_in;
    logic                 in_valid;
    logic                 in_ready;
    logic [BIN_W-1:0]     bin_out;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_err;
    logic                 err_clr;
    logic                 err_sticky;
    logic [ERR_CNT_W-1:0] err_count;

    modport slave (
        input  onehot_in, in_valid, out_ready, err_clr,
        output in_ready, bin_out, out_valid, out_err, err_sticky, err_count
    );

    modport master (
        output onehot_in, in_valid, out_ready, err_clr,
        input  in_ready, bin_out, out_valid, out_err, err_sticky, err_count
    );
endinterface

// File: rtl/onehot_encoder_reg.sv
// Registered one-hot to binary encoder with single-entry output register and illegal-word accounting.
// Define ONEHOT_PRIORITY_EN to encode multi-hot words to their lowest set bit instead of all-ones.
//
// state | meaning
// EMPTY | no result held, out_valid=0
// FULL  | result held on bin_out/out_err, out_valid=1
module onehot_encoder_reg #(
    parameter int OH_W      = 5,
    parameter int BIN_W     = 3,
    parameter int ERR_CNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    onehot_encoder_reg_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t               state_q;
    logic [BIN_W-1:0]     bin_q;
    logic                 err_q;
    logic                 sticky_q;
    logic [ERR_CNT_W-1:0] cnt_q;
    logic [ERR_CNT_W-1:0] cnt_d;
    logic                 sticky_d;

    logic                 in_ready;
    logic                 accept;
    logic [BIN_W-1:0]     enc_bin;
    logic                 enc_err;
    logic [BIN_W-1:0]     low_idx;
    logic                 seen;

    assign in_ready = (state_q == EMPTY) | bus.out_ready;
    assign accept   = bus.in_valid & in_ready;

    always_comb begin
        enc_bin = BIN_W'(OH_W);
        enc_err = 1'b0;
        low_idx = '0;
        seen    = 1'b0;
        for (int i = 0; i < OH_W; i++) begin
            if (bus.onehot_in[i]) begin
                if (seen) enc_err = 1'b1;
                else      low_idx = BIN_W'(i);
                seen = 1'b1;
            end
        end
        if (enc_err) begin
`ifdef ONEHOT_PRIORITY_EN
            enc_bin = low_idx;
`else
            enc_bin = '1;
`endif
        end else if (seen) begin
            enc_bin = low_idx;
        end
    end

    // A new illegal word in the same cycle as err_clr restarts the count at one.
    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (accept && enc_err) begin
            sticky_d = 1'b1;
            if (bus.err_clr)      cnt_d = ERR_CNT_W'(1);
            else if (cnt_q != '1) cnt_d = cnt_q + ERR_CNT_W'(1);
        end else if (bus.err_clr) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= EMPTY;
            bin_q    <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_q <= FULL;
                        bin_q   <= enc_bin;
                        err_q   <= enc_err;
                    end
                end
                FULL: begin
                    if (accept) begin
                        bin_q <= enc_bin;
                        err_q <= enc_err;
                    end else if (bus.out_ready) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = (state_q == FULL);
    assign bus.bin_out    = bin_q;
    assign bus.out_err    = err_q;
    assign bus.err_sticky = sticky_q;
    assign bus.err_count  = cnt_q;
endmodule
